// File: rtl/jtsdram_bank_fill.sv
// Bank fill stage: writes a per-pass LFSR pattern to every address of a bank, then starts the checker.
// Optional macro JTSDRAM_FILL_THROTTLE_EN inserts GAP idle cycles between consecutive writes.
module jtsdram_bank_fill #(
  parameter int unsigned AW   = 22,
  parameter logic [15:0] SEED = 16'h0001,
  parameter int unsigned GAP  = 4
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          start,
  output logic [AW-1:0] addr,
  output logic          wr,
  output logic [31:0]   din,
  input  logic          ack,
  input  logic          rdy,
  output logic [15:0]   data_ref,
  output logic          check_start,
  output logic          done,
  output logic [7:0]    passes
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  // GAP is a 16-bit idle-cycle count at most.
  if (GAP > 32'd65535) begin : g_gap_range
    $error("jtsdram_bank_fill: GAP out of range");
  end

`ifdef JTSDRAM_FILL_THROTTLE_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_GAP} state_t;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [31:0]   din_q, din_d;
  logic [15:0]   ref_q, ref_d;
  logic          cs_q, cs_d;
  logic          done_q, done_d;
  logic [7:0]    passes_q, passes_d;

  function automatic logic [15:0] lfsr(input logic [15:0] r);
    return {1'b0, r[15:1]} ^ (r[0] ? 16'hB400 : 16'h0000);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      din_q    <= 32'h0;
      ref_q    <= SEED_EFF;
      cs_q     <= 1'b0;
      done_q   <= 1'b1;
      passes_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      din_q    <= din_d;
      ref_q    <= ref_d;
      cs_q     <= cs_d;
      done_q   <= done_d;
      passes_q <= passes_d;
    end
  end

`ifdef JTSDRAM_FILL_THROTTLE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) gap_cnt_q <= '0;
    else     gap_cnt_q <= gap_cnt_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    din_d    = din_q;
    ref_d    = ref_q;
    cs_d     = 1'b0;
    done_d   = done_q;
    passes_d = passes_q;
`ifdef JTSDRAM_FILL_THROTTLE_EN
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ref_d   = lfsr(ref_q);
          din_d   = {2{lfsr(ref_q)}};
          addr_d  = '0;
          wr_d    = 1'b1;
          done_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      // rdy is not meaningful until the request is accepted
      S_REQ: begin
        if (ack) begin
          wr_d    = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rdy) begin
          if (&addr_q) begin
            done_d   = 1'b1;
            cs_d     = 1'b1;
            passes_d = passes_q + 8'd1;
            state_d  = S_IDLE;
          end else begin
            addr_d = addr_q + AW'(1);
`ifdef JTSDRAM_FILL_THROTTLE_EN
            if (GAP != 0) begin
              gap_cnt_d = GW'(GAP - 1);
              state_d   = S_GAP;
            end else begin
              wr_d    = 1'b1;
              state_d = S_REQ;
            end
`else
            wr_d    = 1'b1;
            state_d = S_REQ;
`endif
          end
        end
      end
`ifdef JTSDRAM_FILL_THROTTLE_EN
      // hold wr low for exactly GAP cycles
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          wr_d    = 1'b1;
          state_d = S_REQ;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign addr        = addr_q;
  assign wr          = wr_q;
  assign din         = din_q;
  assign data_ref    = ref_q;
  assign check_start = cs_q;
  assign done        = done_q;
  assign passes      = passes_q;

endmodule

// File: tb/tb_jtsdram_bank_fill.sv
// Directed bench for jtsdram_bank_fill with a handshake controller model and an expected-write scoreboard.
module tb_jtsdram_bank_fill;
  localparam int unsigned AW = 4;
  localparam int NW = 16;
`ifdef JTSDRAM_FILL_THROTTLE_EN
  localparam int EXP_GAP = 4;
`else
  localparam int EXP_GAP = 0;
`endif

  logic          rst, clk, start, ack, rdy;
  logic [AW-1:0] addr;
  logic          wr;
  logic [31:0]   din;
  logic [15:0]   data_ref;
  logic          check_start, done;
  logic [7:0]    passes;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } exp_t;
  exp_t sb[$];

  jtsdram_bank_fill #(.AW(AW), .SEED(16'h0001), .GAP(4)) dut (
    .rst(rst), .clk(clk), .start(start), .addr(addr), .wr(wr), .din(din),
    .ack(ack), .rdy(rdy), .data_ref(data_ref), .check_start(check_start),
    .done(done), .passes(passes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_wr"}, 32'(wr), 32'd0);
    check({tag, "_din"}, din, 32'd0);
    check({tag, "_ref"}, 32'(data_ref), 32'h0001);
    check({tag, "_cs"}, 32'(check_start), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_passes"}, 32'(passes), 32'd0);
  endtask

  // pulse start and queue every write the pass is expected to make
  task automatic do_start(input logic [15:0] pat);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < NW; i++) sb.push_back({AW'(i), {pat, pat}});
    @(negedge clk);
    start = 1'b0;
    check("start_wr", 32'(wr), 32'd1);
    check("start_addr", 32'(addr), 32'd0);
    check("start_din", din, {pat, pat});
    check("start_ref", 32'(data_ref), 32'(pat));
    check("start_done", 32'(done), 32'd0);
  endtask

  // controller model: ack one cycle after wr, rdy two cycles after ack
  task automatic run_pass(input int stop_at, input bit stray, input bit both,
                          input logic [15:0] pat, input logic [7:0] exp_passes);
    for (int n = 0; n < NW; n++) begin
      int t;
      int g;
      exp_t e;
      t = 0;
      while (wr !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("wr_timeout", 32'(wr), 32'd1);
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check("wr_addr", 32'(addr), 32'(e.a));
      check("wr_din", din, e.d);
      check("wr_ref", 32'(data_ref), 32'(pat));
      if (n == stop_at) return;
      ack = 1'b1;
      if (stray && n == 3) start = 1'b1;
      if (both && n == 5) rdy = 1'b1;
      @(negedge clk);
      ack = 1'b0; start = 1'b0; rdy = 1'b0;
      check("wr_after_ack", 32'(wr), 32'd0);
      check("addr_hold", 32'(addr), 32'(e.a));
      @(negedge clk);
      rdy = 1'b1;
      if (stray && n == 8) start = 1'b1;
      @(negedge clk);
      rdy = 1'b0; start = 1'b0;
      if (n == NW - 1) begin
        check("last_cs", 32'(check_start), 32'd1);
        check("last_done", 32'(done), 32'd1);
        check("last_wr", 32'(wr), 32'd0);
        check("last_passes", 32'(passes), 32'(exp_passes));
        @(negedge clk);
        check("cs_pulse", 32'(check_start), 32'd0);
        check("done_hold", 32'(done), 32'd1);
        check("addr_last", 32'(addr), 32'(NW - 1));
      end else begin
        g = 0;
        while (wr !== 1'b1 && done !== 1'b1 && g < 50) begin
          @(negedge clk);
          g++;
        end
        check("gap_cycles", 32'(g), 32'(EXP_GAP));
        check("mid_done", 32'(done), 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ack = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_done", 32'(done), 32'd1);
    check("idle_wr", 32'(wr), 32'd0);

    // pass 1, with ack and rdy coincident at address 5
    do_start(16'hB400);
    run_pass(99, 1'b0, 1'b1, 16'hB400, 8'd1);
    check("sb_drained1", 32'(sb.size()), 32'd0);

    // pass 2, with stray start pulses mid-pass
    do_start(16'h5A00);
    run_pass(99, 1'b1, 1'b0, 16'h5A00, 8'd2);
    check("ref_after2", 32'(data_ref), 32'h5A00);
    check("sb_drained2", 32'(sb.size()), 32'd0);

    // pass 3 interrupted by reset at address 7
    do_start(16'h2D00);
    run_pass(7, 1'b0, 1'b0, 16'h2D00, 8'd0);
    check("pre_rst_addr", 32'(addr), 32'd7);
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;

    do_start(16'hB400);
    run_pass(99, 1'b0, 1'b0, 16'hB400, 8'd1);
    check("sb_drained3", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtsdram_bank_fill.md
Name: jtsdram_bank_fill

Overview:
Write-phase stage that sits directly upstream of the bank read checker in the SDRAM test core.
- On a start pulse, writes a 16-bit pattern, duplicated to 32 bits, to every address of one bank through the SDRAM controller's write request/ack/rdy handshake.
- Then presents that pattern on data_ref and fires check_start so the checker verifies the bank.
- The pattern advances through a 16-bit LFSR on every new pass, so successive passes write different data.

Parameters:
AW, 22, address width; the bank spans 2^AW words (benches use small values).
SEED, 16'h0001, LFSR seed loaded into data_ref at reset; a value of 0 is replaced by 16'h0001.
GAP, 4, idle cycles between a write's rdy and the next write request (used only with the optional feature).

Ports:
rst  input  1  reset, asynchronous, active-high
clk  input  1  clock
start  input  1  single-cycle pulse that starts one fill pass
addr  output AW  write address
wr  output  1  write request, held until ack
din  output 32  write data, always {2{data_ref}} of the current pass
ack  input  1  controller accepted the request
rdy  input  1  controller finished the write
data_ref  output 16  pattern of the current pass; stable from start until the next start
check_start  output 1  one-cycle pulse when the fill completes; drives the checker's start
done  output  1  high when idle or finished
passes  output  8  count of completed fills; wraps 255->0

Behaviour:
- Reset values:
  - addr=0, wr=0, din=0, data_ref=SEED (0 replaced by 1), check_start=0, done=1, passes=0.
  - FSM in IDLE.
- States: IDLE, REQ, WAIT, GAP (GAP exists only with the optional feature).
- IDLE + start, next edge:
  - n = lfsr(data_ref); data_ref<=n; din<={2{n}}; addr<=0; wr<=1; done<=0; go to REQ.
- lfsr(r) = {1'b0,r[15:1]} ^ (r[0] ? 16'hB400 : 16'h0).
- start outside IDLE: ignored; no restart, no LFSR advance.
- REQ, wr=1:
  - On ack: wr<=0, go to WAIT.
  - rdy in REQ is ignored.
- WAIT:
  - ack in WAIT is ignored.
  - On rdy with addr == all ones: done<=1, check_start<=1 for exactly one cycle, passes<=passes+1, addr stays, go to IDLE.
  - On rdy otherwise: addr<=addr+1, wr<=1 on the next edge (no idle cycle), go to REQ.
- din and data_ref do not change during a pass.
- Each address is written exactly once per pass, in order 0..2^AW-1. A pass takes at least 2·2^AW cycles when ack and rdy arrive in minimal time.
- check_start and done rise on the same edge; check_start clears on the following edge.
- Reset mid-pass returns every output to its reset value immediately (asynchronous); the LFSR restarts from SEED.

Optional Feature:
Macro JTSDRAM_FILL_THROTTLE_EN.
- Defined: rdy on a non-last address goes to GAP instead of REQ.
  - In GAP: addr<=addr+1 on entry, wr=0 for exactly GAP cycles, then wr<=1 and go to REQ.
  - GAP=0 behaves as if the macro were undefined.
- Undefined: the GAP state and its counter are not synthesised; wr reasserts on the edge after rdy.
- The last address never enters GAP in either build.

Test Plan:
- Reset, AW=4, SEED=1; start pulse -> data_ref=16'hB400, din=32'hB400B400, wr=1, addr=0, done=0 one cycle later.
- Controller model: ack 1 cycle after wr, rdy 2 cycles after ack -> addr runs 0..15, each written once; check_start high exactly 1 cycle with done rising; passes=1.
- Second start after completion -> data_ref=16'h5A00, din=32'h5A005A00, passes=2 at end; start pulses during the pass are ignored and data_ref stays 16'h5A00.
- ack and rdy asserted together while in REQ -> only ack acts, WAIT entered; the following rdy advances addr by exactly 1.
- rst asserted with addr=7 mid-pass -> wr=0, addr=0, done=1, data_ref=16'h0001, passes=0 asynchronously; a new start writes 16'hB400 from addr 0.
- With JTSDRAM_FILL_THROTTLE_EN and GAP=4 -> exactly 4 cycles with wr=0 between each rdy and the next wr; none after address 15.
